dot_product_fsm: RTL and testbench

Sequencer and multiply-accumulate engine that sits directly downstream of the two operand memories (vector A and vector B) in the dot-product datapath. On a start request it sweeps both memories over a programmed length, multiplies the element pairs and accumulates a signed result. It presents the result on a valid/ready output handshake. Both memories share one read port drive from this block; each has one-cycle registered read latency.

---
 rtl/dot_product_fsm.sv | 110 +++++++++++
 tb/tb_dot_product_fsm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_fsm.sv
// Dot-product sequencer: sweeps two operand memories over a programmed length,
// multiplies element pairs and accumulates a signed result behind a valid/ready handshake.
module dot_product_fsm #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int VEC_LEN    = 32,
  parameter int ACC_WIDTH  = 69
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam int                PROD_WIDTH = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_LEN  = (ADDR_WIDTH + 1)'(VEC_LEN);
  localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH:0]          len_q;
  logic [ADDR_WIDTH:0]          len_clamped;
  logic [ADDR_WIDTH:0]          last_idx;
  logic [ADDR_WIDTH-1:0]        idx_q;
  logic                         drain_q;
  logic                         rd_vld_q;
  logic                         prod_vld_q;
  logic signed [PROD_WIDTH-1:0] product_q;
  logic [ACC_WIDTH-1:0]         acc_q;
  logic [ACC_WIDTH-1:0]         acc_next;
  logic [ACC_WIDTH-1:0]         product_ext;
  logic [ACC_WIDTH-1:0]         result_q;
  logic                         accept;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign last_idx    = len_q - LEN_ONE;
  assign accept      = (state_q == IDLE) && start;
  assign product_ext = {{(ACC_WIDTH - PROD_WIDTH){product_q[PROD_WIDTH-1]}}, product_q};
  // The last product lands in the final drain cycle, so the result is captured from acc_next.
  assign acc_next    = prod_vld_q ? (acc_q + product_ext) : acc_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len_clamped == '0) ? DONE : RUN;
      RUN:     if ({1'b0, idx_q} == last_idx) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    read_en      = (state_q == RUN);
    result_valid = (state_q == DONE);
  end

  assign read_address = idx_q;
  assign result       = result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      idx_q      <= '0;
      drain_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      product_q  <= '0;
      acc_q      <= '0;
      result_q   <= '0;
    end else begin
      rd_vld_q   <= read_en;
      prod_vld_q <= rd_vld_q;
      if (rd_vld_q)
        product_q <= (PROD_WIDTH)'($signed(a_data)) * (PROD_WIDTH)'($signed(b_data));

      if (accept) begin
        len_q    <= len_clamped;
        idx_q    <= '0;
        acc_q    <= '0;
        result_q <= '0;
      end else begin
        acc_q <= acc_next;
      end

      if (state_q == RUN) idx_q <= idx_q + 1'b1;

      if (state_q == DRAIN) drain_q <= ~drain_q;
      else                  drain_q <= 1'b0;

      if ((state_q == DRAIN) && drain_q) result_q <= acc_next;
    end
  end

endmodule

// File: tb/tb_dot_product_fsm.sv
// Directed self-checking bench for dot_product_fsm with registered-read memory models.
module tb_dot_product_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  len;
  logic        busy;
  logic        read_en;
  logic [4:0]  read_address;
  logic [31:0] a_data;
  logic [31:0] b_data;
  logic [68:0] result;
  logic        result_valid;
  logic        result_ready;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];

  int n_tests = 0;
  int n_fail  = 0;

  dot_product_fsm #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .VEC_LEN   (32),
    .ACC_WIDTH (69)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .busy        (busy),
    .read_en     (read_en),
    .read_address(read_address),
    .a_data      (a_data),
    .b_data      (b_data),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_en) begin
      a_data <= mem_a[read_address];
      b_data <= mem_b[read_address];
    end
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_ramp(input logic [31:0] bval);
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 32'(i + 1);
      mem_b[i] = bval;
    end
  endtask

  task automatic fill_const(input logic [31:0] aval, input logic [31:0] bval);
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = aval;
      mem_b[i] = bval;
    end
  endtask

  // Caller is at a negedge; cycle 0 is the cycle in which start is sampled.
  task automatic run_vec(input string tag, input logic [5:0] l, input bit prestarted,
                         input bit poke, input logic [68:0] exp_res, input int exp_lat,
                         input int exp_reads, input int exp_last);
    int lat = 0;
    int nreads = 0;
    int last = -1;
    int addr_err = 0;
    if (!prestarted) begin
      start = 1'b1;
      len   = l;
    end
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (poke && c == 2) begin
        start = 1'b1;
        len   = 6'd1;
      end
      if (poke && c == 3) start = 1'b0;
      if (read_en) begin
        if (read_address != 5'(nreads)) addr_err++;
        last = int'(read_address);
        nreads++;
      end
      if (result_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, 72'(lat), 72'(exp_lat));
    check({tag, "_result"}, 72'(result), 72'(exp_res));
    check({tag, "_reads"}, 72'(nreads), 72'(exp_reads));
    check({tag, "_addr_order"}, 72'(addr_err), 72'(0));
    if (exp_reads > 0) check({tag, "_last_addr"}, 72'(last), 72'(exp_last));
  endtask

  task automatic ack(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    check({tag, "_ack_busy"}, 72'(busy), 72'(0));
    check({tag, "_ack_valid"}, 72'(result_valid), 72'(0));
    result_ready = 1'b0;
  endtask

  initial begin
    logic [68:0] big;
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    result_ready = 1'b0;
    fill_ramp(32'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_read_en", 72'(read_en), 72'(0));
    check("rst_addr", 72'(read_address), 72'(0));
    check("rst_result", 72'(result), 72'(0));
    check("rst_valid", 72'(result_valid), 72'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic run with a start pulse during RUN that must be ignored.
    run_vec("basic", 6'd4, 1'b0, 1'b1, 69'd20, 7, 4, 3);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        start = 1'b1;
        len   = 6'd1;
      end
      if (i == 4) start = 1'b0;
      @(negedge clk);
      check("hold_valid", 72'(result_valid), 72'(1));
      check("hold_result", 72'(result), 72'(20));
    end
    ack("basic");
    check("idle_result_kept", 72'(result), 72'(20));

    // Full-scale negative operands: 32 * 2^62 = 2^67.
    fill_const(32'h8000_0000, 32'h8000_0000);
    big = '0;
    big[67] = 1'b1;
    run_vec("fullscale", 6'd32, 1'b0, 1'b0, big, 35, 32, 31);
    ack("fullscale");

    run_vec("len0", 6'd0, 1'b0, 1'b0, 69'd0, 1, 0, 0);
    ack("len0");

    fill_ramp(32'd1);
    run_vec("len40", 6'd40, 1'b0, 1'b0, 69'd528, 35, 32, 31);
    ack("len40");

    // Reset in the middle of a run.
    fill_const(32'd1, 32'd1);
    start = 1'b1;
    len   = 6'd8;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 72'(busy), 72'(0));
    check("midrst_read_en", 72'(read_en), 72'(0));
    check("midrst_addr", 72'(read_address), 72'(0));
    check("midrst_result", 72'(result), 72'(0));
    check("midrst_valid", 72'(result_valid), 72'(0));
    rst = 1'b0;
    @(negedge clk);
    run_vec("after_rst", 6'd8, 1'b0, 1'b0, 69'd8, 11, 8, 7);
    ack("after_rst");

    // Back-to-back with ready tied high; start held from the first valid cycle.
    fill_ramp(32'd1);
    result_ready = 1'b1;
    run_vec("b2b_first", 6'd3, 1'b0, 1'b0, 69'd6, 6, 3, 2);
    start = 1'b1;
    len   = 6'd5;
    @(negedge clk);
    check("b2b_idle_busy", 72'(busy), 72'(0));
    check("b2b_idle_valid", 72'(result_valid), 72'(0));
    run_vec("b2b_second", 6'd5, 1'b1, 1'b0, 69'd15, 8, 5, 4);
    @(negedge clk);
    check("b2b_end_busy", 72'(busy), 72'(0));
    result_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
